serial_frame_receiver: RTL

- Receive-side counterpart of the calculator's serial transmit path.
- Takes the serial stream (data bit, valid qualifier, divided transmit clock) and reassembles each 32-bit frame.
- Splits each frame into its fields (A, B, ALU result, SEL, FLAGS) and reports frame errors.
- Runs entirely on the system clock; the transmit clock is treated as a sampled data signal, not as a clock.

---
 rtl/serial_frame_receiver_pkg.sv | 17 +
 rtl/sync_edge_detect.sv | 39 +++
 rtl/serial_frame_receiver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame path: field positions within a
// 32-bit frame and the receiver state encoding.
package serial_frame_receiver_pkg;

  localparam int unsigned A_MSB    = 31;
  localparam int unsigned B_MSB    = 23;
  localparam int unsigned RES_MSB  = 15;
  localparam int unsigned SEL_MSB  = 7;
  localparam int unsigned FLAG_MSB = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_LOW = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with an optional rising-edge pulse on the
// synchronized output.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_DETECT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic [SYNC_STAGES:0]   taps;
  logic                   prev_q, prev_d;

  // Input at the bottom of the tap vector keeps the single-stage case legal.
  assign taps = {chain_q, d_in};

  always_comb begin
    chain_d = taps[SYNC_STAGES-1:0];
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign d_sync = chain_q[SYNC_STAGES-1];
  assign rise   = EDGE_DETECT && d_sync && !prev_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Reassembles MSB-first serial frames sampled on rising edges of the divided
// transmit clock, all in the system clock domain, and splits them into fields.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SIN,
  input  logic             VALID_IN,
  input  logic             CLK_Tx_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic [7:0]       A_OUT,
  output logic [7:0]       B_OUT,
  output logic [7:0]       RESULT_OUT,
  output logic [3:0]       SEL_OUT,
  output logic [3:0]       FLAGS_OUT,
  output logic             DATA_OUT_VALID,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  output logic             RX_BUSY
);

  localparam int unsigned        CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   FULL  = CNT_W'(WIDTH);

  logic sin_s, valid_s, tick;
  logic sin_rise_unused, valid_rise_unused, clk_tx_s_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_sin_sync (
    .clk(CLK), .rst(RESET), .d_in(SIN), .d_sync(sin_s), .rise(sin_rise_unused)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_valid_sync (
    .clk(CLK), .rst(RESET), .d_in(VALID_IN), .d_sync(valid_s), .rise(valid_rise_unused)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_clk_tx_sync (
    .clk(CLK), .rst(RESET), .d_in(CLK_Tx_IN), .d_sync(clk_tx_s_unused), .rise(tick)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_busy;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (tick && valid_s) begin
          shift_d = {shift_q[WIDTH-2:0], sin_s};
          count_d = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A full register is published one cycle after the last bit lands.
        if (count_q == FULL) begin
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          state_d      = WAIT_LOW;
          if (tick && valid_s) overrun_d = 1'b1;
        end else if (!valid_s) begin
          frame_err_d = 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end else if (tick) begin
          shift_d = {shift_q[WIDTH-2:0], sin_s};
          count_d = count_q + CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (!valid_s) begin
          count_d = '0;
          state_d = IDLE;
        end else if (tick) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state_q == SHIFT) || (state_q == WAIT_LOW);
  end

  assign DATA_OUT       = data_out_q;
  assign A_OUT          = data_out_q[A_MSB -: 8];
  assign B_OUT          = data_out_q[B_MSB -: 8];
  assign RESULT_OUT     = data_out_q[RES_MSB -: 8];
  assign SEL_OUT        = data_out_q[SEL_MSB -: 4];
  assign FLAGS_OUT      = data_out_q[FLAG_MSB -: 4];
  assign DATA_OUT_VALID = data_valid_q;
  assign FRAME_ERR      = frame_err_q;
  assign OVERRUN        = overrun_q;
  assign RX_BUSY        = rx_busy;

endmodule
